// File: rtl/ex_mem_stage_pkg.sv
// rtl/ex_mem_stage_pkg.sv - shared encodings for the EX/MEM pipeline stage and its test monitor
package ex_mem_stage_pkg;

    // Default width of data, PC and branch-target buses
    localparam int DATA_BUS = 32;

    // Test-state encodings carried on ex_test_state and reported on test_status
    localparam logic [1:0] TEST_NONE = 2'd0;
    localparam logic [1:0] TEST_PASS = 2'd1;
    localparam logic [1:0] TEST_FAIL = 2'd2;
    localparam logic [1:0] TEST_DONE = 2'd3;

    // Test-monitor FSM states; FAILED and DONE are terminal
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FAILED = 2'd1,
        ST_DONE   = 2'd2
    } mon_state_t;

    // Externally visible status code for a monitor state
    function automatic logic [1:0] status_of(input mon_state_t state);
        case (state)
            ST_FAILED: status_of = TEST_FAIL;
            ST_DONE:   status_of = TEST_DONE;
            default:   status_of = TEST_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ex_mem_stage_test_monitor.sv
// rtl/ex_mem_stage_test_monitor.sv - pass/fail counters and RUN/FAILED/DONE halt FSM
module test_monitor
    import ex_mem_stage_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_accept,
    input  logic [1:0]             i_test_state,
    output logic [1:0]             o_test_status,
    output logic [COUNT_WIDTH-1:0] o_pass_count,
    output logic [COUNT_WIDTH-1:0] o_fail_count,
    output logic                   o_halted
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = 1;

    mon_state_t             r_state;
    mon_state_t             w_state_next;
    logic [COUNT_WIDTH-1:0] r_pass_count;
    logic [COUNT_WIDTH-1:0] r_fail_count;
    logic                   w_pass_inc;
    logic                   w_fail_inc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and counter enables; only an accepted instruction in RUN has any effect
    always_comb begin
        w_state_next = r_state;
        w_pass_inc   = 1'b0;
        w_fail_inc   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_accept) begin
                    case (i_test_state)
                        TEST_PASS: w_pass_inc = 1'b1;
                        TEST_FAIL: begin
                            w_fail_inc   = 1'b1;
                            w_state_next = ST_FAILED;
                        end
                        TEST_DONE: w_state_next = ST_DONE;
                        default:   ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Saturating pass/fail counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass_count <= '0;
            r_fail_count <= '0;
        end else begin
            if (w_pass_inc && (r_pass_count != '1)) begin
                r_pass_count <= r_pass_count + COUNT_ONE;
            end
            if (w_fail_inc && (r_fail_count != '1)) begin
                r_fail_count <= r_fail_count + COUNT_ONE;
            end
        end
    end

    assign o_halted      = (r_state != ST_RUN);
    assign o_test_status = status_of(r_state);
    assign o_pass_count  = r_pass_count;
    assign o_fail_count  = r_fail_count;

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with branch redirect and test monitor
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_BUS,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   ex_valid,
    input  logic [DATA_WIDTH-1:0]  ex_pc,
    input  logic [DATA_WIDTH-1:0]  ex_result,
    input  logic                   ex_branch,
    input  logic [DATA_WIDTH-1:0]  ex_branch_target,
    input  logic [1:0]             ex_test_state,
    input  logic [4:0]             ex_dest_reg,
    input  logic                   ex_reg_write,
    input  logic                   ex_mem_read,
    input  logic                   ex_mem_write,
    input  logic [DATA_WIDTH-1:0]  ex_store_data,
    output logic                   mem_valid,
    output logic [DATA_WIDTH-1:0]  mem_pc,
    output logic [DATA_WIDTH-1:0]  mem_result,
    output logic [4:0]             mem_dest_reg,
    output logic                   mem_reg_write,
    output logic                   mem_mem_read,
    output logic                   mem_mem_write,
    output logic [DATA_WIDTH-1:0]  mem_store_data,
    output logic                   redirect_valid,
    output logic [DATA_WIDTH-1:0]  redirect_pc,
    output logic [1:0]             test_status,
    output logic [COUNT_WIDTH-1:0] pass_count,
    output logic [COUNT_WIDTH-1:0] fail_count,
    output logic                   halted
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_result;
    logic [4:0]            r_dest_reg;
    logic                  r_reg_write;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [DATA_WIDTH-1:0] r_store_data;
    logic                  r_redirect_valid;
    logic [DATA_WIDTH-1:0] r_redirect_pc;
    logic                  w_halted;
    logic                  w_accept;

    // Once halted, nothing new enters the stage until reset
    assign w_accept = ex_valid & ~stall & ~flush & ~w_halted;

    // Payload register: flush beats stall; an idle or halted cycle becomes a bubble
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !w_accept)) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_result     <= '0;
            r_dest_reg   <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_store_data <= '0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_pc         <= ex_pc;
            r_result     <= ex_result;
            r_dest_reg   <= ex_dest_reg;
            r_reg_write  <= ex_reg_write;
            r_mem_read   <= ex_mem_read;
            r_mem_write  <= ex_mem_write;
            r_store_data <= ex_store_data;
        end
    end

    // One-cycle fetch redirect for each accepted taken branch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_accept & ex_branch;
            if (w_accept && ex_branch) begin
                r_redirect_pc <= ex_branch_target;
            end
        end
    end

    test_monitor #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_test_monitor (
        .clk           (clk),
        .rst           (rst),
        .i_accept      (w_accept),
        .i_test_state  (ex_test_state),
        .o_test_status (test_status),
        .o_pass_count  (pass_count),
        .o_fail_count  (fail_count),
        .o_halted      (w_halted)
    );

    assign mem_valid      = r_valid;
    assign mem_pc         = r_pc;
    assign mem_result     = r_result;
    assign mem_dest_reg   = r_dest_reg;
    assign mem_reg_write  = r_reg_write;
    assign mem_mem_read   = r_mem_read;
    assign mem_mem_write  = r_mem_write;
    assign mem_store_data = r_store_data;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign halted         = w_halted;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of data, PC and branch-target buses.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, width of test pass/fail counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports stall, flush  input  1 each  pipeline hold and bubble-insert requests.
REQ-006 SHALL have ports ex_valid (1), ex_pc (DATA_WIDTH), ex_result (DATA_WIDTH, ALU rd), ex_branch (1, ALU branch), ex_branch_target (DATA_WIDTH), ex_test_state (2, ALU test_state)  inputs  execute-stage payload.
REQ-007 SHALL have ports ex_dest_reg (5), ex_reg_write (1), ex_mem_read (1), ex_mem_write (1), ex_store_data (DATA_WIDTH)  inputs  decoded controls carried alongside.
REQ-008 SHALL have ports mem_valid, mem_pc, mem_result, mem_dest_reg, mem_reg_write, mem_mem_read, mem_mem_write, mem_store_data  outputs  registered copies of the REQ-006/007 payload, same widths.
REQ-009 SHALL have ports redirect_valid (1), redirect_pc (DATA_WIDTH)  outputs  taken-branch fetch redirect.
REQ-010 SHALL have ports test_status (2), pass_count (COUNT_WIDTH), fail_count (COUNT_WIDTH), halted (1)  outputs  test monitor state.

Function
REQ-011 SHALL define accept = ex_valid & ~stall & ~flush & ~halted, evaluated per cycle.
REQ-012 SHALL, on accept, load all mem_* payload registers from ex_* inputs with mem_valid=1; latency exactly one cycle.
REQ-013 SHALL, when flush=1 (priority over stall), load mem_valid, mem_reg_write, mem_mem_read, mem_mem_write and all data registers with 0.
REQ-014 SHALL, when stall=1 and flush=0, hold every mem_* register unchanged.
REQ-015 SHALL, when ex_valid=0 or halted=1 with no stall/flush, insert a bubble (same zeroing as REQ-013).
REQ-016 SHALL assert redirect_valid for exactly one cycle following an accept with ex_branch=1, redirect_pc = that ex_branch_target; redirect_valid=0 in all other cycles, including stall cycles.
REQ-017 SHALL implement test-monitor FSM states RUN, FAILED, DONE; test_status outputs 0, TEST_FAIL, TEST_DONE respectively.
REQ-018 SHALL, on accept with ex_test_state=TEST_PASS, increment pass_count, saturating at all-ones; FSM stays RUN.
REQ-019 SHALL, on accept with ex_test_state=TEST_FAIL, increment fail_count (saturating) and move RUN->FAILED.
REQ-020 SHALL, on accept with ex_test_state=TEST_DONE, move RUN->DONE.
REQ-021 SHALL treat FAILED and DONE as terminal; halted=1 in both, so no further accepts, counters frozen.
REQ-022 SHALL ignore ex_test_state when not accepted (stalled, flushed, invalid).
REQ-023 SHALL let the instruction that causes halting complete normally (it is captured per REQ-012).

Reset
REQ-024 SHALL, with rst=1 at a clock edge, clear all mem_* outputs, redirect_valid, redirect_pc, pass_count, fail_count to 0, FSM to RUN, halted to 0.
REQ-025 SHALL give rst priority over flush, stall and accept, including mid-stall or while halted.

Structure
REQ-026 SHALL take TEST_PASS, TEST_FAIL, TEST_DONE encodings and DATA_BUS width macros from the shared defines.v; FSM state encodings also live there.
REQ-027 SHALL contain one natural sub-module, test_monitor (REQ-017 to REQ-022), instantiated once; payload registers stay in ex_mem_stage.

Verification
REQ-028 SHALL verify: accept ex_result=0x12345678, dest=5, reg_write=1 -> next cycle mem_valid=1, mem_result=0x12345678, mem_dest_reg=5.
REQ-029 SHALL verify: stall held 3 cycles after capture while ex_* changes -> mem_* unchanged all 3 cycles; stall+flush together -> mem_valid=0 next cycle.
REQ-030 SHALL verify: accept with ex_branch=1, target 0x00000040 -> redirect_valid=1 for exactly one cycle with redirect_pc=0x40; same with stall=1 -> no redirect.
REQ-031 SHALL verify: 3 accepted TEST_PASS then TEST_FAIL then TEST_PASS -> pass_count=3, fail_count=1, test_status=TEST_FAIL, halted=1, final PASS ignored, mem_valid=0 after.
REQ-032 SHALL verify: COUNT_WIDTH=2 with 5 PASS accepts -> pass_count saturates at 3.
REQ-033 SHALL verify: rst asserted while DONE and stalled -> next cycle all outputs 0, halted=0, subsequent accept captured.
